// File: rtl/dp_matrix_sched_if.sv
// rtl/dp_matrix_sched_if.sv - control, accumulator and readout signals of dp_matrix_sched
//
// Purpose: bundles every signal of dp_matrix_sched except clk/rst.
// Ports (modport master = scheduler side, slave = environment side):
//   start, abort, sample_valid   window control and sample qualifier into the scheduler
//   matrix                       flat accumulator cell bus, cell k at [k*CNT_W +: CNT_W]
//   acc_clr, acc_en              accumulator clear and sample enable
//   rd_valid, rd_ready           readout handshake
//   rd_data, rd_idx, rd_last     current readout cell value, index and final-cell marker
//   busy, done, sat              status: not idle, window complete pulse, saturation seen
interface dp_matrix_sched_if #(
    parameter int MA_SIZE = 4,
    parameter int CNT_W   = 9
) ();
    localparam int N_CELLS = MA_SIZE * MA_SIZE;
    localparam int IDX_W   = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;

    logic                     start;
    logic                     abort;
    logic                     sample_valid;
    logic [CNT_W*N_CELLS-1:0] matrix;
    logic                     acc_clr;
    logic                     acc_en;
    logic                     rd_valid;
    logic                     rd_ready;
    logic [CNT_W-1:0]         rd_data;
    logic [IDX_W-1:0]         rd_idx;
    logic                     rd_last;
    logic                     busy;
    logic                     done;
    logic                     sat;

    modport master (
        input  start, abort, sample_valid, matrix, rd_ready,
        output acc_clr, acc_en, rd_valid, rd_data, rd_idx, rd_last, busy, done, sat
    );

    modport slave (
        output start, abort, sample_valid, matrix, rd_ready,
        input  acc_clr, acc_en, rd_valid, rd_data, rd_idx, rd_last, busy, done, sat
    );
endinterface

// File: rtl/dp_matrix_sched.sv
// rtl/dp_matrix_sched.sv - accumulation window scheduler with snapshot cell readout
//
// Purpose: clears an external accumulator, enables it for WIN_LEN valid samples,
// waits ACC_LAT cycles for the last update to land, snapshots the cell matrix and
// streams the cells out over a valid/ready handshake.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   dp_matrix_sched_if.master (see interface for the signal list)
// Parameters: MA_SIZE matrix edge, CNT_W cell width, WIN_LEN samples per window
// (1..65535), ACC_LAT accumulator latency in cycles (>= 1).
module dp_matrix_sched #(
    parameter int MA_SIZE = 4,
    parameter int CNT_W   = 9,
    parameter int WIN_LEN = 256,
    parameter int ACC_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    dp_matrix_sched_if.master bus
);
    localparam int N_CELLS = MA_SIZE * MA_SIZE;
    localparam int IDX_W   = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
    localparam int DRN_W   = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
    localparam logic [CNT_W-1:0] CELL_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_READOUT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_smp_cnt;
    logic [DRN_W-1:0] r_drain_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_snap [N_CELLS];
    logic             r_sat;

    logic             w_last_smp;
    logic             w_last_beat;
    logic             w_xfer;
    logic             w_acc_clr;
    logic             w_acc_en;
    logic             w_rd_valid;
    logic [CNT_W-1:0] w_rd_data;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_rd_last;
    logic             w_done;

    assign w_last_smp  = bus.sample_valid && (r_smp_cnt == 16'(WIN_LEN - 1));
    assign w_last_beat = (r_idx == IDX_W'(N_CELLS - 1));
    // An aborted beat does not count as transferred, so it neither advances nor sets sat.
    assign w_xfer      = (r_state == S_READOUT) && bus.rd_ready && !bus.abort;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_clr   = 1'b0;
        w_acc_en    = 1'b0;
        w_rd_valid  = 1'b0;
        w_rd_data   = '0;
        w_rd_idx    = '0;
        w_rd_last   = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_acc_clr   = 1'b1;
                w_state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                w_acc_en = bus.sample_valid;
                if (w_last_smp) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_nxt = S_READOUT;
                end
            end
            S_READOUT: begin
                w_rd_valid = 1'b1;
                w_rd_data  = r_snap[r_idx];
                w_rd_idx   = r_idx;
                w_rd_last  = w_last_beat;
                if (bus.rd_ready && w_last_beat) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Abort overrides every other transition, including the completing sample and final beat.
        if (bus.abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_acc_en    = 1'b0;
            w_done      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_smp_cnt   <= '0;
            r_drain_cnt <= '0;
            r_idx       <= '0;
            r_sat       <= 1'b0;
            for (int k = 0; k < N_CELLS; k++) begin
                r_snap[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    // Clearing on CLEAR entry keeps sat low for the whole CLEAR cycle.
                    if (w_state_nxt == S_CLEAR) begin
                        r_smp_cnt <= '0;
                        r_sat     <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_smp_cnt <= '0;
                    r_sat     <= 1'b0;
                end
                S_ACCUM: begin
                    if (bus.sample_valid) begin
                        r_smp_cnt <= r_smp_cnt + 16'd1;
                    end
                    if (w_state_nxt == S_DRAIN) begin
                        r_drain_cnt <= DRN_W'(ACC_LAT - 1);
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt != '0) begin
                        r_drain_cnt <= r_drain_cnt - DRN_W'(1);
                    end
                    if (w_state_nxt == S_READOUT) begin
                        r_idx <= '0;
                        for (int k = 0; k < N_CELLS; k++) begin
                            r_snap[k] <= bus.matrix[k*CNT_W +: CNT_W];
                        end
                    end
                end
                S_READOUT: begin
                    if (w_xfer) begin
                        r_idx <= r_idx + IDX_W'(1);
                        if (r_snap[r_idx] == CELL_MAX) begin
                            r_sat <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.acc_clr  = w_acc_clr;
    assign bus.acc_en   = w_acc_en;
    assign bus.rd_valid = w_rd_valid;
    assign bus.rd_data  = w_rd_data;
    assign bus.rd_idx   = w_rd_idx;
    assign bus.rd_last  = w_rd_last;
    assign bus.done     = w_done;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.sat      = r_sat;
endmodule

// File: tb/tb_dp_matrix_sched.sv
// tb/tb_dp_matrix_sched.sv - scoreboard bench for dp_matrix_sched
module tb_dp_matrix_sched;
    localparam int MA   = 4;
    localparam int CW   = 9;
    localparam int WIN  = 4;
    localparam int LAT  = 2;
    localparam int N    = MA * MA;
    localparam int MAXV = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dp_matrix_sched_if #(.MA_SIZE(MA), .CNT_W(CW)) bus ();

    dp_matrix_sched #(.MA_SIZE(MA), .CNT_W(CW), .WIN_LEN(WIN), .ACC_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int idx;
        int data;
        bit last;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    bit    m_sat = 1'b0;
    int    done_seen = 0;
    int    cells[N];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented beat with the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("sat", bus.sat, m_sat);
                if (bus.done) done_seen++;
                if (bus.rd_valid && !bus.abort) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got beat idx %0d, expected no beat", bus.rd_idx);
                    end else begin
                        chk("rd_idx", bus.rd_idx, exp_q[0].idx);
                        chk("rd_data", bus.rd_data, exp_q[0].data);
                        chk("rd_last", bus.rd_last, exp_q[0].last);
                        if (bus.rd_ready) begin
                            chk("done_on_beat", bus.done, exp_q[0].last);
                            if (exp_q[0].data == MAXV) m_sat = 1'b1;
                            void'(exp_q.pop_front());
                        end else begin
                            chk("done_stall", bus.done, 0);
                        end
                    end
                end else begin
                    chk("done_no_beat", bus.done, 0);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_acc_clr"}, bus.acc_clr, 0);
        chk({tag, "_acc_en"}, bus.acc_en, 0);
        chk({tag, "_rd_valid"}, bus.rd_valid, 0);
        chk({tag, "_rd_data"}, bus.rd_data, 0);
        chk({tag, "_rd_idx"}, bus.rd_idx, 0);
        chk({tag, "_rd_last"}, bus.rd_last, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_sat"}, bus.sat, 0);
    endtask

    // cmode 0: cell k = k+1; 1: random below max; 2: random with cell 5 at max; 3: random, max 1/8 of the time
    task automatic load_cells(input int cmode);
        for (int k = 0; k < N; k++) begin
            case (cmode)
                0:       cells[k] = k + 1;
                3:       cells[k] = ($urandom_range(0, 7) == 0) ? MAXV : $urandom_range(0, MAXV - 1);
                default: cells[k] = $urandom_range(0, MAXV - 1);
            endcase
            if (cmode == 2 && k == 5) cells[k] = MAXV;
            bus.matrix[k*CW +: CW] = CW'(cells[k]);
        end
    endtask

    function automatic bit ready_val(input int rmode, input int cyc);
        case (rmode)
            0:       return 1'b1;
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            default: return 1'(($urandom_range(0, 99) < 60));
        endcase
    endfunction

    task automatic start_window();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        m_sat = 1'b0;
        @(negedge clk);
        chk("clear_acc_clr", bus.acc_clr, 1);
        chk("clear_acc_en", bus.acc_en, 0);
        chk("clear_busy", bus.busy, 1);
        chk("clear_sat", bus.sat, 0);
    endtask

    // Returns ok=0 when the window was aborted or timed out.
    task automatic accumulate(input int vpct, input int abort_smp, input int start_cyc, output bit ok);
        int acc = 0;
        int cyc = 0;
        bit aborted = 1'b0;
        int en_cnt = 0;
        ok = 1'b1;
        while (acc < WIN && cyc < 2000 && !aborted) begin
            step();
            bus.sample_valid = ($urandom_range(0, 99) < vpct);
            bus.abort = bus.sample_valid && (acc + 1 == abort_smp);
            bus.start = (cyc == start_cyc);
            @(negedge clk);
            chk("accum_acc_en", bus.acc_en, bus.sample_valid && !bus.abort);
            chk("accum_acc_clr", bus.acc_clr, 0);
            if (bus.acc_en) en_cnt++;
            if (bus.sample_valid) acc++;
            if (bus.abort) aborted = 1'b1;
            cyc++;
        end
        bus.start = 1'b0;
        if (cyc >= 2000) begin
            chk("accum_timeout", acc, WIN);
            ok = 1'b0;
        end else if (aborted) begin
            step();
            bus.abort = 1'b0;
            bus.sample_valid = 1'b0;
            @(negedge clk);
            chk("abort_accum_busy", bus.busy, 0);
            chk("abort_accum_rd_valid", bus.rd_valid, 0);
            chk("abort_accum_acc_en", bus.acc_en, 0);
            ok = 1'b0;
        end else begin
            chk("accum_en_cycles", en_cnt, WIN);
        end
    endtask

    task automatic drain_phase(output bit ok);
        int n = 0;
        ok = 1'b0;
        chk("queue_empty_at_drain", exp_q.size(), 0);
        exp_q.delete();
        for (int k = 0; k < N; k++) exp_q.push_back('{k, cells[k], (k == N - 1)});
        step();
        bus.sample_valid = 1'($urandom_range(0, 1));
        repeat (LAT + 3) begin
            @(negedge clk);
            if (bus.rd_valid) begin
                ok = 1'b1;
                break;
            end
            chk("drain_acc_en", bus.acc_en, 0);
            chk("drain_busy", bus.busy, 1);
            n++;
            step();
        end
        bus.sample_valid = 1'b0;
        if (ok) begin
            chk("drain_len", n, LAT);
            // The snapshot is already taken; later matrix changes must not reach rd_data.
            for (int k = 0; k < N; k++) bus.matrix[k*CW +: CW] = CW'($urandom);
        end else begin
            chk("rd_valid_timeout", bus.rd_valid, 1);
            exp_q.delete();
            rst = 1'b1;
            step();
            rst = 1'b0;
            m_sat = 1'b0;
        end
    endtask

    task automatic readout(input int rmode, input int abort_beat, input int rst_beat, output bit ok);
        int beats = 0;
        int cyc = 0;
        ok = 1'b0;
        while (cyc < 400) begin
            step();
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
            bus.rd_ready = ready_val(rmode, cyc);
            bus.abort = (abort_beat >= 0) && (beats == abort_beat) && bus.rd_ready;
            if (rst_beat >= 0 && beats == rst_beat) begin
                #1 rst = 1'b1;
                #1;
                check_all_zero("rst_async");
                exp_q.delete();
                m_sat = 1'b0;
                bus.rd_ready = 1'b0;
                step();
                rst = 1'b0;
                return;
            end
            @(negedge clk);
            if (bus.rd_valid && bus.rd_ready && !bus.abort) beats++;
            if (bus.abort) begin
                step();
                bus.abort = 1'b0;
                bus.rd_ready = 1'b0;
                @(negedge clk);
                chk("abort_rd_busy", bus.busy, 0);
                chk("abort_rd_valid", bus.rd_valid, 0);
                exp_q.delete();
                return;
            end
            cyc++;
        end
        bus.rd_ready = 1'b0;
        chk("readout_complete", ok, 1);
        chk("readout_beats", beats, N);
        chk("queue_drained", exp_q.size(), 0);
        chk("idle_rd_valid", bus.rd_valid, 0);
    endtask

    task automatic run_window(input int cmode, input int vpct, input int rmode,
                              input int abort_smp, input int abort_beat, input int rst_beat,
                              input int start_cyc);
        int d0;
        bit ok;
        d0 = done_seen;
        load_cells(cmode);
        start_window();
        accumulate(vpct, abort_smp, start_cyc, ok);
        if (ok) drain_phase(ok);
        if (ok) readout(rmode, abort_beat, rst_beat, ok);
        @(negedge clk);
        chk("done_pulses", done_seen - d0, ok ? 1 : 0);
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.sample_valid = 1'b0;
        bus.rd_ready     = 1'b0;
        bus.matrix       = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        step();
        rst = 1'b0;

        // Stay idle without start; abort in IDLE does nothing.
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_idle", bus.busy, 0);
        end

        // Back-to-back samples, cells k+1, ready held high.
        run_window(0, 100, 0, -1, -1, -1, -1);
        // Ready pattern 1,0,0,1 with a start pulse ignored during ACCUM.
        run_window(1, 100, 1, -1, -1, -1, 1);
        // Abort together with the completing sample.
        run_window(1, 100, 0, WIN, -1, -1, -1);
        // Saturated cell 5, then a window without saturation clears sat.
        run_window(2, 100, 0, -1, -1, -1, -1);
        chk("sat_sticky_after_window", bus.sat, 1);
        run_window(1, 70, 2, -1, -1, -1, -1);
        // Abort on the final beat.
        run_window(3, 100, 0, -1, N - 1, -1, -1);
        // Reset during beat 7, then a clean window.
        run_window(3, 100, 0, -1, -1, 7, -1);
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_idle", bus.busy, 0);
        end
        run_window(0, 100, 0, -1, -1, -1, -1);

        for (int w = 0; w < 8; w++) begin
            run_window(3, $urandom_range(30, 100), $urandom_range(0, 2), -1, -1, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dp_matrix_sched.md
DP_MATRIX_SCHED -- requirements
Module: dp_matrix_sched

Interface
REQ-001: Parameter MA_SIZE, default 4, is the matrix edge length; the block handles MA_SIZE*MA_SIZE cells.
REQ-002: Parameter CNT_W, default 9, is the width of each accumulator cell.
REQ-003: Parameter WIN_LEN, default 256, is the number of valid samples per accumulation window (range 1..65535).
REQ-004: Parameter ACC_LAT, default 2, is the cycles from sample acceptance to the cell update in the accumulator.
REQ-005: clk  input  1  single clock, all logic on its rising edge.
REQ-006: rst  input  1  asynchronous, active-high reset.
REQ-007: start  input  1  one-cycle pulse that requests a new window.
REQ-008: abort  input  1  one-cycle pulse that cancels the current window.
REQ-009: sample_valid  input  1  an I/Q sample is present at the accumulator input this cycle.
REQ-010: matrix  input  CNT_W*MA_SIZE*MA_SIZE  flat cell bus from the accumulator; cell k occupies bits [k*CNT_W +: CNT_W].
REQ-011: acc_clr  output  1  clears all accumulator cells.
REQ-012: acc_en  output  1  qualifies the sample into the accumulator.
REQ-013: rd_valid / rd_ready  output / input  1 each  readout handshake.
REQ-014: rd_data  output  CNT_W  value of the current cell.
REQ-015: rd_idx  output  clog2(MA_SIZE*MA_SIZE)  index of the current cell.
REQ-016: rd_last  output  1  marks the final cell.
REQ-017: busy  output  1  high in any state except IDLE.
REQ-018: done  output  1  one-cycle pulse when a window completes.
REQ-019: sat  output  1  sticky flag: some cell reached 2^CNT_W-1 during the last readout.

Function
REQ-020: The FSM SHALL have five states: IDLE, CLEAR, ACCUM, DRAIN and READOUT.
REQ-021: In IDLE, start SHALL cause a transition to CLEAR; a start pulse in any other state SHALL be ignored.
REQ-022: CLEAR SHALL last exactly 1 cycle with acc_clr=1, SHALL clear the sample counter and sat, then go to ACCUM.
REQ-023: In ACCUM, acc_en SHALL equal sample_valid combinationally, and the 16-bit sample counter SHALL increment on each valid sample.
REQ-024: When the WIN_LEN-th valid sample is accepted, the FSM SHALL go to DRAIN; acc_en SHALL be 0 from the next cycle on.
REQ-025: DRAIN SHALL last exactly ACC_LAT cycles (down-counter), then go to READOUT with rd_idx=0.
REQ-026: On READOUT entry, the block SHALL register a snapshot of matrix, and rd_data SHALL read from that snapshot.
REQ-027: In READOUT, rd_valid SHALL be 1 and rd_data SHALL equal cell rd_idx of the snapshot.
REQ-028: rd_data, rd_idx and rd_last SHALL stay stable while rd_valid=1 and rd_ready=0.
REQ-029: A beat SHALL transfer when rd_valid and rd_ready are both 1; rd_idx SHALL then increment.
REQ-030: rd_last SHALL be 1 exactly when rd_idx equals MA_SIZE*MA_SIZE-1.
REQ-031: The transfer of the rd_last beat SHALL pulse done for 1 cycle, return the FSM to IDLE and drop rd_valid in the next cycle.
REQ-032: sat SHALL be set on any transferred beat whose rd_data equals 2^CNT_W-1, and SHALL hold until the next CLEAR or reset.
REQ-033: abort in CLEAR, ACCUM, DRAIN or READOUT SHALL force IDLE on the next edge, with no done pulse and acc_en=0 immediately.
REQ-034: abort SHALL have priority over all other transitions in the same cycle, including a completing sample and the final beat.
REQ-035: abort in IDLE SHALL have no effect.
REQ-036: When WIN_LEN=1, the first valid sample SHALL end ACCUM.
REQ-037: When sample_valid is held low, the block SHALL remain in ACCUM indefinitely.
REQ-038: outputs acc_en, rd_valid, rd_data, rd_idx and rd_last SHALL be 0 in every state where they are not defined above.

Reset
REQ-039: Asserting rst SHALL immediately force IDLE, clear all counters and the snapshot, and set every output to 0.
REQ-040: Asserting rst in the middle of a window or a readout SHALL discard that window.
REQ-041: After rst deasserts, the block SHALL stay in IDLE until the next start pulse.

Verification
REQ-042: Test: WIN_LEN=4, ACC_LAT=2, start followed by 4 consecutive valid samples -> acc_clr high 1 cycle; acc_en high 4 cycles; DRAIN lasts 2 cycles; rd_valid rises 1 cycle after DRAIN ends.
REQ-043: Test: readout with rd_ready held high, cell k preset to k+1 -> 16 beats carrying rd_data 1..16 and rd_idx 0..15; rd_last and done occur on beat 15.
REQ-044: Test: readout with rd_ready toggling 1,0,0,1 -> rd_data and rd_idx hold during stalls; no beat is lost or duplicated.
REQ-045: Test: abort in the same cycle as the 4th valid sample -> next state is IDLE; no DRAIN; no done.
REQ-046: Test: cell 5 equal to 511 with CNT_W=9 -> sat=1 after beat 5; sat clears in the CLEAR of the next window.
REQ-047: Test: rst asserted during beat 7 of READOUT -> all outputs 0 asynchronously; after release, the next start runs a clean window.
